// File: rtl/cpu_pad_bus_bridge_if.sv
// Core/pad-bus bundle for cpu_pad_bus_bridge.
//   Core side : req, memwrite_a, memwrite_b, adr, memOut -> bridge; memdata, busy, done, err <- bridge
//   Pad side  : pad_out, pad_out_valid -> pad; pad_out_ready <- pad
//               pad_in, pad_in_valid <- pad (no backpressure)
// slave modport is the bridge view; master modport is the core/pad driver view.
interface cpu_pad_bus_bridge_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PAD_W  = 4
);
   logic              req;
   logic              memwrite_a;
   logic              memwrite_b;
   logic [DATA_W-1:0] adr;
   logic [DATA_W-1:0] memOut;
   logic [DATA_W-1:0] memdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [PAD_W-1:0]  pad_out;
   logic              pad_out_valid;
   logic              pad_out_ready;
   logic [PAD_W-1:0]  pad_in;
   logic              pad_in_valid;

   modport slave (
      input  req, memwrite_a, memwrite_b, adr, memOut,
      input  pad_out_ready, pad_in, pad_in_valid,
      output memdata, busy, done, err, pad_out, pad_out_valid
   );

   modport master (
      output req, memwrite_a, memwrite_b, adr, memOut,
      output pad_out_ready, pad_in, pad_in_valid,
      input  memdata, busy, done, err, pad_out, pad_out_valid
   );
endinterface

// File: rtl/cpu_pad_bus_bridge.sv
// Serialises a core memory transaction onto a narrow pad bus.
// Sequence: one command beat {memwrite_b, memwrite_a}, N address beats,
// then N write-data beats (write) or N inbound read beats (read), all MSB-first,
// followed by a one-cycle done pulse. A read that sees TIMEOUT consecutive
// cycles without pad_in_valid ends early with err=1 and memdata untouched.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - cpu_pad_bus_bridge_if.slave (core request/response + pad handshake)
module cpu_pad_bus_bridge #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned PAD_W   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input logic                  clk,
   input logic                  reset,
   cpu_pad_bus_bridge_if.slave  bus
);

   localparam int unsigned N  = DATA_W / PAD_W;
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
   localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        state;
   logic [DATA_W-1:0] out_sh;      // outbound shifter, top beat is on pad_out
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] in_sh;
   logic [DATA_W-1:0] in_next;
   logic [DATA_W-1:0] memdata_q;
   logic              mw_a_q;
   logic              mw_b_q;
   logic              err_q;
   logic [CW-1:0]     beat_cnt;
   logic [TW-1:0]     idle_cnt;
   logic              out_valid;
   logic              out_xfer;
   logic              last_beat;
   logic [PAD_W-1:0]  pad_out_d;

   assign out_valid = (state == S_CMD) || (state == S_ADDR) || (state == S_WDATA);
   assign out_xfer  = out_valid && bus.pad_out_ready;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign in_next   = (in_sh << PAD_W) | DATA_W'(bus.pad_in);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         out_sh    <= '0;
         wdata_q   <= '0;
         in_sh     <= '0;
         memdata_q <= '0;
         mw_a_q    <= 1'b0;
         mw_b_q    <= 1'b0;
         err_q     <= 1'b0;
         beat_cnt  <= '0;
         idle_cnt  <= '0;
      end else begin
         // err is a single-cycle flag that lines up with the DONE state
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req) begin
                  out_sh   <= bus.adr;
                  wdata_q  <= bus.memOut;
                  mw_a_q   <= bus.memwrite_a;
                  mw_b_q   <= bus.memwrite_b;
                  beat_cnt <= '0;
                  state    <= S_CMD;
               end
            end
            S_CMD: begin
               if (out_xfer) state <= S_ADDR;
            end
            S_ADDR: begin
               if (out_xfer) begin
                  out_sh <= out_sh << PAD_W;
                  if (last_beat) begin
                     beat_cnt <= '0;
                     idle_cnt <= '0;
                     if (mw_a_q || mw_b_q) begin
                        out_sh <= wdata_q;
                        state  <= S_WDATA;
                     end else begin
                        state  <= S_RDATA;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            S_WDATA: begin
               if (out_xfer) begin
                  out_sh <= out_sh << PAD_W;
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= S_DONE;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            S_RDATA: begin
               if (bus.pad_in_valid) begin
                  in_sh    <= in_next;
                  idle_cnt <= '0;
                  if (last_beat) begin
                     memdata_q <= in_next;
                     beat_cnt  <= '0;
                     state     <= S_DONE;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end else if (idle_cnt == LAST_IDLE) begin
                  err_q    <= 1'b1;
                  idle_cnt <= '0;
                  beat_cnt <= '0;
                  state    <= S_DONE;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      pad_out_d = '0;
      case (state)
         S_CMD:           pad_out_d = PAD_W'({mw_b_q, mw_a_q});
         S_ADDR, S_WDATA: pad_out_d = out_sh[DATA_W-1 -: PAD_W];
         default:         pad_out_d = '0;
      endcase
   end

   assign bus.pad_out       = pad_out_d;
   assign bus.pad_out_valid = out_valid;
   assign bus.busy          = (state != S_IDLE);
   assign bus.done          = (state == S_DONE);
   assign bus.err           = err_q;
   assign bus.memdata       = memdata_q;

endmodule

// File: tb/tb_cpu_pad_bus_bridge.sv
// Directed bench for cpu_pad_bus_bridge (DATA_W=16, PAD_W=4, TIMEOUT=255).
// A negedge monitor logs every outbound transfer and every done/err pulse;
// the stimulus sequence compares those logs against hand-written beat lists.
module tb_cpu_pad_bus_bridge;

   logic clk;
   logic reset;

   cpu_pad_bus_bridge_if #(.DATA_W(16), .PAD_W(4)) bus_if ();

   cpu_pad_bus_bridge #(
      .DATA_W (16),
      .PAD_W  (4),
      .TIMEOUT(255)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [3:0]  beats[$];
   int          beat_cyc[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          done_cyc = 0;
   logic        err_at_done = 1'b0;
   logic [15:0] memdata_at_done = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus_if.pad_out_valid && bus_if.pad_out_ready) begin
         beats.push_back(bus_if.pad_out);
         beat_cyc.push_back(cyc);
      end
      if (bus_if.done) begin
         done_cnt        = done_cnt + 1;
         done_cyc        = cyc;
         err_at_done     = bus_if.err;
         memdata_at_done = bus_if.memdata;
      end
      if (bus_if.err) err_cnt = err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      beats.delete();
      beat_cyc.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic start(input logic wa, input logic wb, input logic [15:0] a, input logic [15:0] d);
      clear_mon();
      bus_if.memwrite_a = wa;
      bus_if.memwrite_b = wb;
      bus_if.adr        = a;
      bus_if.memOut     = d;
      bus_if.req        = 1'b1;
      tick();
      bus_if.req        = 1'b0;
   endtask

   // Leaves the bench at negedge+1 of the cycle on which beat n is presented.
   task automatic wait_beats(input int n);
      int k = 0;
      while (beats.size() < n && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("wait_beats", beats.size(), n);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("done_seen", done_cnt, 1);
   endtask

   // exp holds the beats MSB-first, one hex digit per beat.
   task automatic check_beats(input string tag, input int n, input logic [35:0] exp);
      check({tag, "_count"}, beats.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_beat"}, (i < beats.size()) ? 32'(beats[i]) : 32'hDEAD, 32'(exp[4*(n-1-i) +: 4]));
      end
   endtask

   initial begin
      reset                = 1'b1;
      bus_if.req           = 1'b0;
      bus_if.memwrite_a    = 1'b0;
      bus_if.memwrite_b    = 1'b0;
      bus_if.adr           = '0;
      bus_if.memOut        = '0;
      bus_if.pad_out_ready = 1'b1;
      bus_if.pad_in        = '0;
      bus_if.pad_in_valid  = 1'b0;

      // reset state
      tick();
      tick();
      check("rst_busy",    bus_if.busy, 0);
      check("rst_done",    bus_if.done, 0);
      check("rst_err",     bus_if.err, 0);
      check("rst_valid",   bus_if.pad_out_valid, 0);
      check("rst_pad_out", bus_if.pad_out, 0);
      check("rst_memdata", bus_if.memdata, 0);
      reset = 1'b0;
      tick();

      // write: cmd 1, addr 1234, data ABCD on 9 consecutive cycles
      start(1'b1, 1'b0, 16'h1234, 16'hABCD);
      wait_done(50);
      check_beats("wr", 9, 36'h11234ABCD);
      check("wr_consec",   beat_cyc[8] - beat_cyc[0], 8);
      check("wr_done_lat", done_cyc - beat_cyc[8], 1);
      check("wr_err",      err_at_done, 0);
      tick();
      tick();
      check("wr_one_done", done_cnt, 1);
      check("wr_idle",     bus_if.busy, 0);

      // read 00F0, inbound 5,A,(gap),5,A; stray pad_in_valid before RDATA ignored
      bus_if.pad_in       = 4'h7;
      bus_if.pad_in_valid = 1'b1;
      start(1'b0, 1'b0, 16'h00F0, 16'h0000);
      wait_beats(5);
      tick();
      bus_if.pad_in = 4'h5;
      tick();
      bus_if.pad_in = 4'hA;
      tick();
      bus_if.pad_in_valid = 1'b0;
      tick();
      bus_if.pad_in_valid = 1'b1;
      bus_if.pad_in       = 4'h5;
      tick();
      bus_if.pad_in = 4'hA;
      tick();
      bus_if.pad_in_valid = 1'b0;
      wait_done(20);
      check_beats("rd", 5, 36'h0000F0);
      check("rd_memdata_done", memdata_at_done, 16'h5A5A);
      check("rd_err",          err_at_done, 0);
      tick();
      check("rd_memdata",      bus_if.memdata, 16'h5A5A);

      // backpressure while second address beat (2) is presented
      start(1'b1, 1'b0, 16'h1234, 16'hABCD);
      wait_beats(2);
      tick();
      bus_if.pad_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_hold", bus_if.pad_out, 4'h2);
         check("bp_valid", bus_if.pad_out_valid, 1);
         tick();
      end
      bus_if.pad_out_ready = 1'b1;
      wait_done(50);
      check_beats("bp", 9, 36'h11234ABCD);

      // read timeout: 255 idle RDATA cycles
      tick();
      start(1'b0, 1'b0, 16'h4321, 16'h0000);
      wait_done(400);
      check("to_err",      err_at_done, 1);
      check("to_err_cnt",  err_cnt, 1);
      check("to_latency",  done_cyc - beat_cyc[4], 256);
      check("to_memdata",  memdata_at_done, 16'h5A5A);

      // reset during WDATA abandons the write
      tick();
      start(1'b1, 1'b0, 16'h1234, 16'hABCD);
      wait_beats(6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rw_busy",  bus_if.busy, 0);
      check("rw_valid", bus_if.pad_out_valid, 0);
      tick();
      tick();
      check("rw_no_done", done_cnt, 0);

      // following write, dual strobe via memwrite_b only
      start(1'b0, 1'b1, 16'h0F0F, 16'h1357);
      wait_done(50);
      check_beats("rw2", 9, 36'h20F0F1357);

      // req pulsed during ADDR with a different address is ignored
      tick();
      start(1'b1, 1'b0, 16'hABCD, 16'h9876);
      wait_beats(2);
      bus_if.req        = 1'b1;
      bus_if.adr        = 16'hFFFF;
      bus_if.memOut     = 16'h0000;
      bus_if.memwrite_b = 1'b1;
      tick();
      bus_if.req = 1'b0;
      wait_done(50);
      tick();
      tick();
      tick();
      check_beats("ign", 9, 36'h1ABCD9876);
      check("ign_one_done", done_cnt, 1);
      check("ign_idle",     bus_if.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_pad_bus_bridge.md
CPU_PAD_BUS_BRIDGE -- requirements
Module: cpu_pad_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, core address/data width.
REQ-002 SHALL have parameter PAD_W, default 4, pad-bus beat width; DATA_W SHALL be a multiple of PAD_W and PAD_W >= 2.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum idle cycles allowed between read-data beats.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port req, input, 1, core transaction request, sampled only in IDLE.
REQ-007 SHALL have ports memwrite_a and memwrite_b, input, 1 each, write strobes; transaction is a write if either is set.
REQ-008 SHALL have port adr, input, DATA_W, transaction address.
REQ-009 SHALL have port memOut, input, DATA_W, write data.
REQ-010 SHALL have port memdata, output, DATA_W, last successful read data.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, one-cycle pulse coincident with done on read timeout.
REQ-014 SHALL have port pad_out, output, PAD_W, outbound beat.
REQ-015 SHALL have port pad_out_valid, output, 1, and port pad_out_ready, input, 1, outbound handshake.
REQ-016 SHALL have port pad_in, input, PAD_W, and port pad_in_valid, input, 1, inbound beats, no backpressure.

Function
REQ-017 SHALL implement states IDLE, CMD, ADDR, WDATA, RDATA, DONE; N = DATA_W/PAD_W.
REQ-018 IDLE with req=1 SHALL latch adr, memOut, memwrite_a, memwrite_b and enter CMD next cycle.
REQ-019 An outbound beat SHALL transfer only on a cycle with pad_out_valid=1 and pad_out_ready=1.
REQ-020 pad_out_valid SHALL be 1 in CMD, ADDR, WDATA and 0 elsewhere; pad_out SHALL be held stable while valid and not ready.
REQ-021 CMD beat SHALL be pad_out[1:0]={memwrite_b,memwrite_a}, upper bits 0; both strobes set is a legal dual write (2'b11).
REQ-022 ADDR SHALL send N beats of the latched address, most significant beat first, then go to WDATA if write, else RDATA.
REQ-023 WDATA SHALL send N beats of latched write data MSB-first, then go to DONE.
REQ-024 RDATA SHALL shift in pad_in on each pad_in_valid cycle MSB-first; after N beats go to DONE and load memdata.
REQ-025 RDATA SHALL count cycles without pad_in_valid, clearing on each beat; at TIMEOUT go to DONE with err=1, memdata unchanged.
REQ-026 DONE SHALL assert done for exactly one cycle then return to IDLE; a new req may be accepted the cycle after DONE.
REQ-027 req while busy=1 SHALL be ignored; pad_in_valid outside RDATA SHALL be ignored.
REQ-028 Beat counter SHALL be sized ceil(log2(N+1)) and never wrap within a phase.

Reset
REQ-029 reset=1 SHALL force IDLE on the next edge from any state, abandoning any transaction without done.
REQ-030 After reset: busy=0, done=0, err=0, pad_out_valid=0, pad_out=0, memdata=0, counters=0.

Verification (DATA_W=16, PAD_W=4, TIMEOUT=255)
REQ-031 Write: req, memwrite_a=1, adr=16'h1234, memOut=16'hABCD, ready=1 -> beats 1,1,2,3,4,A,B,C,D on 9 consecutive cycles, done next cycle, err=0.
REQ-032 Read: adr=16'h00F0, pad_in beats 5,A,5,A -> outbound 0,0,0,F,0; memdata=16'h5A5A with done, err=0.
REQ-033 Backpressure: ready=0 for 3 cycles after 2nd address beat -> pad_out held 4'h2, no beat lost, 9 beats total.
REQ-034 Timeout: read with no pad_in_valid -> done=1, err=1 after 255 RDATA cycles; memdata keeps prior 16'h5A5A.
REQ-035 Reset during WDATA -> next cycle busy=0, pad_out_valid=0, no done; following write completes normally.
REQ-036 req pulsed during ADDR with different adr -> ignored; original transaction beats unchanged, one done only.
